sync_fifo_param: RTL and testbench
==================================

SYNC_FIFO_PARAM -- requirements
Module: sync_fifo_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, data width in bits.
REQ-002 SHALL provide parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL provide parameter AF_LEVEL, default DEPTH-2, almost-full threshold, 1..DEPTH-1.
REQ-004 SHALL provide parameter AE_LEVEL, default 2, almost-empty threshold, 1..DEPTH-1.
REQ-005 SHALL provide parameter FWFT, default 0, read mode: 0 = registered read, 1 = first-word-fall-through.
REQ-006 SHALL derive localparam ADDR_WIDTH = $clog2(DEPTH).
REQ-007 SHALL have one clock and an asynchronous, active-high reset, with ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  asynchronous active-high reset
- wr_en_i  input  1  write request
- wdata_i  input  WIDTH  write data
- rd_en_i  input  1  read request
- rdata_o  output  WIDTH  read data
- full_o  output  1  count == DEPTH
- empty_o  output  1  count == 0
- almost_full_o  output  1  count >= AF_LEVEL
- almost_empty_o  output  1  count <= AE_LEVEL
- count_o  output  ADDR_WIDTH+1  current fill level
- overflow_o  output  1  one-cycle pulse: write rejected
- underflow_o  output  1  one-cycle pulse: read rejected
- error_o  output  1  sticky OR of overflow/underflow, cleared only by reset

Function
REQ-008 Read SHALL be accepted when rd_en_i=1 and empty_o=0; otherwise rd_en_i=1 SHALL pulse underflow_o next cycle, with no pointer change.
REQ-009 Write SHALL be accepted when wr_en_i=1 and (full_o=0, or a read is accepted that cycle); otherwise wr_en_i=1 SHALL pulse overflow_o next cycle, memory and pointers unchanged.
REQ-010 Simultaneous accepted read+write SHALL leave count_o unchanged; at full, both are accepted; at empty, only the write is accepted (underflow pulses).
REQ-011 Read/write pointers SHALL be ADDR_WIDTH+1 bits, increment by 1 per accepted op, and wrap modulo 2*DEPTH; memory index = low ADDR_WIDTH bits.
REQ-012 count_o SHALL be registered: +1 write-only, -1 read-only, else hold; it never leaves 0..DEPTH.
REQ-013 full_o, empty_o, almost_full_o and almost_empty_o SHALL be decoded from registered count_o and update the cycle after the causing edge.
REQ-014 FWFT=0: rdata_o SHALL register the head entry on the accepting edge (valid one cycle after rd_en_i sampled) and hold otherwise.
REQ-015 FWFT=1: rdata_o SHALL show the head entry combinationally while empty_o=0; an accepted read advances to the next entry; value while empty is don't-care.
REQ-016 Write data SHALL be visible to a read no earlier than the cycle after it is written (no same-cycle bypass at empty).

Reset
REQ-017 rst_i=1 SHALL asynchronously force pointers=0, count_o=0, empty_o=1, almost_empty_o=1, full_o=0, almost_full_o=0, overflow_o=0, underflow_o=0, error_o=0, rdata_o=0.
REQ-018 Storage array SHALL NOT be reset; reset mid-operation discards all contents, and the first post-reset write lands at index 0.

Structure
REQ-019 Shared package fifo_pkg SHALL hold default WIDTH/DEPTH constants and threshold defaults, reused by later FIFO variants.
REQ-020 Storage SHALL be sub-module fifo_mem_2p: one synchronous write port, one asynchronous read port, no reset.
REQ-021 Pointer/count/flag logic SHALL stay in sync_fifo_param; fifo_mem_2p carries no control logic.

Verification (WIDTH=4, DEPTH=16, AF_LEVEL=14, AE_LEVEL=2)
REQ-022 16 writes, no reads -> full_o=1, count_o=16, almost_full_o=1 from count 14; 17th write -> overflow_o pulse, error_o=1, contents intact.
REQ-023 Write 15 then read 15, FWFT=0 -> rdata sequence matches write order, empty_o=1, almost_empty_o=1 from count 2 down.
REQ-024 Read 17 after reset -> underflow_o pulses on every request, count_o stays 0, error_o=1.
REQ-025 Full FIFO, wr_en_i=rd_en_i=1 for 20 cycles -> no overflow, count_o=16, data order preserved across pointer wrap.
REQ-026 FWFT=1, write 0xA then 0x5 -> rdata_o=0xA the cycle after first write, 0x5 after one accepted read.
REQ-027 Assert rst_i mid-transfer at count 9 -> all outputs at reset values immediately, next write/read returns the newly written data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers, reused by the synchronous FIFO and later variants.
package fifo_pkg;

    localparam int unsigned FIFO_DEF_WIDTH    = 4;
    localparam int unsigned FIFO_DEF_DEPTH    = 16;
    localparam int unsigned FIFO_DEF_AE_LEVEL = 2;

    // Encoding is {write_accepted, read_accepted} so the cast below is direct.
    typedef enum logic [1:0] {
        OpNone  = 2'b00,
        OpRead  = 2'b01,
        OpWrite = 2'b10,
        OpBoth  = 2'b11
    } fifo_op_e;

    function automatic int unsigned fifo_af_default(input int unsigned depth);
        return depth - 2;
    endfunction

    function automatic fifo_op_e fifo_op(input logic wr_acc, input logic rd_acc);
        return fifo_op_e'({wr_acc, rd_acc});
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// Two-port storage array: synchronous write, asynchronous read, no reset, no control logic.
module fifo_mem_2p #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [WIDTH-1:0]      rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sync_fifo_param.sv
// Parameterised synchronous FIFO with registered or first-word-fall-through read,
// registered fill count, threshold flags and overflow/underflow reporting.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH    = FIFO_DEF_WIDTH,
    parameter int unsigned DEPTH    = FIFO_DEF_DEPTH,
    parameter int unsigned AF_LEVEL = fifo_af_default(DEPTH),
    parameter int unsigned AE_LEVEL = FIFO_DEF_AE_LEVEL,
    parameter int unsigned FWFT     = 0,
    localparam int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wr_en_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic                  rd_en_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDR_WIDTH:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o,
    output logic                  error_o
);

    localparam int unsigned        CNT_W     = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_CNT    = CNT_W'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_CNT    = CNT_W'(AE_LEVEL);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic                error_q, error_d;
    logic [WIDTH-1:0]    rdata_q, rdata_d;
    logic [WIDTH-1:0]    head;
    logic                full, empty;
    logic                rd_acc, wr_acc;
    fifo_op_e            op;

    fifo_mem_2p #(
        .WIDTH      (WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wdata_i),
        .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (head)
    );

    // Flags come from the registered count, so they follow the causing edge by one cycle.
    assign full  = (count_q == DEPTH_CNT);
    assign empty = (count_q == '0);

    always_comb begin
        rd_acc = rd_en_i && !empty;
        // At full a simultaneous accepted read frees the slot being written.
        wr_acc = wr_en_i && (!full || rd_acc);
        op     = fifo_op(wr_acc, rd_acc);

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case (op)
            OpWrite: count_d = count_q + 1'b1;
            OpRead:  count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        overflow_d  = wr_en_i && !wr_acc;
        underflow_d = rd_en_i && !rd_acc;
        error_d     = error_q || overflow_d || underflow_d;

        rdata_d = rdata_q;
        if ((FWFT == 0) && rd_acc) begin
            rdata_d = head;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            error_q     <= 1'b0;
            rdata_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            error_q     <= error_d;
            rdata_q     <= rdata_d;
        end
    end

    always_comb begin
        full_o         = full;
        empty_o        = empty;
        almost_full_o  = (count_q >= AF_CNT);
        almost_empty_o = (count_q <= AE_CNT);
        count_o        = count_q;
        overflow_o     = overflow_q;
        underflow_o    = underflow_q;
        error_o        = error_q;
        // In fall-through mode the empty value is forced to zero so reset reads back as zero.
        if (FWFT != 0) begin
            rdata_o = empty ? '0 : head;
        end else begin
            rdata_o = rdata_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a registered-read and a fall-through instance share stimulus.
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [3:0] wdata;
    logic       rd_en;

    logic [3:0] rdata, fw_rdata;
    logic       full, empty, af, ae, ovf, unf, err;
    logic       fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf, fw_err;
    logic [4:0] count, fw_count;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
    ) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
        .rdata_o(rdata), .full_o(full), .empty_o(empty), .almost_full_o(af),
        .almost_empty_o(ae), .count_o(count), .overflow_o(ovf), .underflow_o(unf),
        .error_o(err)
    );

    sync_fifo_param #(
        .WIDTH(4), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)
    ) dut_fw (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wdata_i(wdata), .rd_en_i(rd_en),
        .rdata_o(fw_rdata), .full_o(fw_full), .empty_o(fw_empty), .almost_full_o(fw_af),
        .almost_empty_o(fw_ae), .count_o(fw_count), .overflow_o(fw_ovf),
        .underflow_o(fw_unf), .error_o(fw_err)
    );

    logic [11:0] stat, fw_stat;
    assign stat    = {full, empty, af, ae, ovf, unf, err, count};
    assign fw_stat = {fw_full, fw_empty, fw_af, fw_ae, fw_ovf, fw_unf, fw_err, fw_count};

    // Expected {full, empty, af, ae, ovf, unf, err, count} for a given fill level.
    function automatic logic [11:0] mk_stat(input int cnt, input logic o, input logic u,
                                            input logic e);
        return {cnt == 16, cnt == 0, cnt >= 14, cnt <= 2, o, u, e, 5'(cnt)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic w, input logic [3:0] d, input logic r);
        wr_en = w;
        wdata = d;
        rd_en = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        wdata = 4'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    typedef struct {
        logic       wr;
        logic [3:0] wd;
        logic       rd;
        int         cnt;
        logic       unf;
        logic       err;
        logic [3:0] rd_exp;
        logic [3:0] fw_exp;
    } vec_t;

    vec_t vecs [11];
    logic [3:0] model [$];
    logic [3:0] exp_d;

    initial begin
        vecs[0]  = '{1'b1, 4'h3, 1'b0, 1, 1'b0, 1'b0, 4'h0, 4'h3};
        vecs[1]  = '{1'b1, 4'h7, 1'b0, 2, 1'b0, 1'b0, 4'h0, 4'h3};
        vecs[2]  = '{1'b1, 4'h9, 1'b0, 3, 1'b0, 1'b0, 4'h0, 4'h3};
        vecs[3]  = '{1'b1, 4'hC, 1'b1, 3, 1'b0, 1'b0, 4'h3, 4'h7};
        vecs[4]  = '{1'b0, 4'h0, 1'b1, 2, 1'b0, 1'b0, 4'h7, 4'h9};
        vecs[5]  = '{1'b0, 4'h0, 1'b1, 1, 1'b0, 1'b0, 4'h9, 4'hC};
        vecs[6]  = '{1'b0, 4'h0, 1'b1, 0, 1'b0, 1'b0, 4'hC, 4'h0};
        vecs[7]  = '{1'b0, 4'h0, 1'b1, 0, 1'b1, 1'b1, 4'hC, 4'h0};
        vecs[8]  = '{1'b1, 4'h5, 1'b1, 1, 1'b1, 1'b1, 4'hC, 4'h5};
        vecs[9]  = '{1'b0, 4'h0, 1'b0, 1, 1'b0, 1'b1, 4'hC, 4'h5};
        vecs[10] = '{1'b0, 4'h0, 1'b1, 0, 1'b0, 1'b1, 4'h5, 4'h0};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; wdata = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_status", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b0)));
        chk("reset_rdata", 32'(rdata), 32'h0);
        chk("reset_fw_rdata", 32'(fw_rdata), 32'h0);
        rst = 1'b0;

        // Mixed table: fill, simultaneous op, drain, underflow, write-at-empty with read.
        foreach (vecs[i]) begin
            step(vecs[i].wr, vecs[i].wd, vecs[i].rd);
            chk($sformatf("tbl%0d_status", i), 32'(stat),
                32'(mk_stat(vecs[i].cnt, 1'b0, vecs[i].unf, vecs[i].err)));
            chk($sformatf("tbl%0d_fw_status", i), 32'(fw_stat),
                32'(mk_stat(vecs[i].cnt, 1'b0, vecs[i].unf, vecs[i].err)));
            chk($sformatf("tbl%0d_rdata", i), 32'(rdata), 32'(vecs[i].rd_exp));
            chk($sformatf("tbl%0d_fw_rdata", i), 32'(fw_rdata), 32'(vecs[i].fw_exp));
        end

        // Fill to full, overflow, then verify contents survived.
        do_reset();
        chk("fill_post_reset", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b0)));
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'(i), 1'b0);
            chk($sformatf("fill%0d", i), 32'(stat), 32'(mk_stat(i + 1, 1'b0, 1'b0, 1'b0)));
        end
        step(1'b1, 4'hF, 1'b0);
        chk("overflow_pulse", 32'(stat), 32'(mk_stat(16, 1'b1, 1'b0, 1'b1)));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'h0, 1'b1);
            chk($sformatf("full_drain%0d_rdata", i), 32'(rdata), 32'(i));
            chk($sformatf("full_drain%0d", i), 32'(stat), 32'(mk_stat(15 - i, 1'b0, 1'b0, 1'b1)));
        end

        // Write 15, read 15 in order.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 4'(15 - i), 1'b0);
            chk($sformatf("w15_%0d", i), 32'(stat), 32'(mk_stat(i + 1, 1'b0, 1'b0, 1'b0)));
        end
        for (int i = 0; i < 15; i++) begin
            step(1'b0, 4'h0, 1'b1);
            chk($sformatf("r15_%0d_rdata", i), 32'(rdata), 32'(15 - i));
            chk($sformatf("r15_%0d", i), 32'(stat), 32'(mk_stat(14 - i, 1'b0, 1'b0, 1'b0)));
        end

        // Reads from empty.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            step(1'b0, 4'h0, 1'b1);
            chk($sformatf("underflow%0d", i), 32'(stat), 32'(mk_stat(0, 1'b0, 1'b1, 1'b1)));
        end
        step(1'b0, 4'h0, 1'b0);
        chk("underflow_clear", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b1)));

        // Full FIFO with continuous read+write across pointer wrap.
        do_reset();
        model.delete();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 4'((i * 3) & 15), 1'b0);
            model.push_back(4'((i * 3) & 15));
        end
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 4'((i + 5) & 15), 1'b1);
            exp_d = model.pop_front();
            model.push_back(4'((i + 5) & 15));
            chk($sformatf("stream%0d_rdata", i), 32'(rdata), 32'(exp_d));
            chk($sformatf("stream%0d", i), 32'(stat), 32'(mk_stat(16, 1'b0, 1'b0, 1'b0)));
        end
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 4'h0, 1'b1);
            exp_d = model.pop_front();
            chk($sformatf("wrap_drain%0d", i), 32'(rdata), 32'(exp_d));
        end
        chk("wrap_empty", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b0)));

        // Fall-through head presentation.
        do_reset();
        step(1'b1, 4'hA, 1'b0);
        chk("fwft_first", 32'(fw_rdata), 32'hA);
        step(1'b1, 4'h5, 1'b0);
        chk("fwft_hold", 32'(fw_rdata), 32'hA);
        step(1'b0, 4'h0, 1'b1);
        chk("fwft_advance", 32'(fw_rdata), 32'h5);
        chk("fwft_reg_rdata", 32'(rdata), 32'hA);

        // Asynchronous reset in the middle of a transfer at count 9.
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 4'(i + 1), 1'b0);
        end
        step(1'b1, 4'h7, 1'b1);
        chk("pre_rst_count", 32'(stat), 32'(mk_stat(9, 1'b0, 1'b0, 1'b0)));
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_status", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b0)));
        chk("async_rst_rdata", 32'(rdata), 32'h0);
        chk("async_rst_fw_rdata", 32'(fw_rdata), 32'h0);
        @(posedge clk);
        #1;
        chk("rst_hold_status", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b0)));
        rst = 1'b0;
        step(1'b1, 4'hB, 1'b0);
        chk("post_rst_write", 32'(stat), 32'(mk_stat(1, 1'b0, 1'b0, 1'b0)));
        chk("post_rst_fw_rdata", 32'(fw_rdata), 32'hB);
        step(1'b0, 4'h0, 1'b1);
        chk("post_rst_rdata", 32'(rdata), 32'hB);
        chk("post_rst_empty", 32'(stat), 32'(mk_stat(0, 1'b0, 1'b0, 1'b0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
